// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the BCD down counter.
//   state_e   : controller state (IDLE, RUN, EXPIRED)
//   BCD_MAX   : largest legal BCD digit (9)
//   BCD_ZERO  : BCD zero digit
//   bcd_clamp : forces any digit above 9 down to 9
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-BCD nibbles (A..F) saturate to 9 rather than wrapping.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// -----------------------------------------------------------------------------
// bcd_digit_dec
// One BCD digit of the decrement chain (purely combinational).
//   i_digit  : current digit value (0..9)
//   i_dec    : borrow in; decrement this digit when high
//   o_digit  : digit value after the optional decrement
//   o_borrow : borrow out to the next digit (i_dec && digit == 0)
// -----------------------------------------------------------------------------
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dec,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  logic w_is_zero;

  assign w_is_zero = (i_digit == BCD_ZERO);

  // A zero digit wraps to 9 and pushes the borrow upward.
  always_comb begin
    o_digit = i_digit;
    if (i_dec) begin
      if (w_is_zero) o_digit = BCD_MAX;
      else           o_digit = i_digit - 4'd1;
    end
  end

  assign o_borrow = i_dec && w_is_zero;

endmodule

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
// Multi-digit packed BCD countdown timer.
//   clk      : system clock, rising edge
//   rstn     : asynchronous active-low reset
//   load     : synchronous load strobe (highest priority)
//   load_val : packed BCD start value, digit 0 in [3:0]; digits > 9 clamp to 9
//   start    : leave IDLE and begin counting (ignored at zero / in RUN / EXPIRED)
//   en       : tick enable, one decrement per high cycle while running
//   count    : current packed BCD value
//   running  : high in RUN
//   zero     : combinational, high when count == 0
//   done     : registered one-cycle pulse on expiry
// Optional build macro BCD_AUTORELOAD_EN: the last loaded value is kept in a
// reload register and restored on expiry, so the counter stays in RUN as a
// periodic timer. A reload value of zero falls back to the plain behaviour.
// -----------------------------------------------------------------------------
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam logic [4*DIGITS-1:0] CNT_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_e                   r_state;
  logic [DIGITS-1:0][3:0]   r_count;
  logic                     r_done;
`ifdef BCD_AUTORELOAD_EN
  logic [DIGITS-1:0][3:0]   r_reload;
`endif

  logic [DIGITS-1:0][3:0]   w_load_clamped;
  logic [DIGITS-1:0][3:0]   w_dec_val;
  logic [DIGITS:0]          w_borrow;
  logic                     w_zero;
  logic                     w_tick;
  logic                     w_expire;

  // ---------------------------------------------------------------------------
  // Per-digit clamp and decrement chain
  // ---------------------------------------------------------------------------
  // Decrement only on a live tick in RUN; load overrides the tick.
  assign w_tick      = (r_state == RUN) && en && !load;
  assign w_borrow[0] = w_tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_load_clamped[g] = bcd_clamp(load_val[4*g +: 4]);

    bcd_digit_dec u_dig (
      .i_digit  (r_count[g]),
      .i_dec    (w_borrow[g]),
      .o_digit  (w_dec_val[g]),
      .o_borrow (w_borrow[g+1])
    );
  end

  assign w_zero   = (r_count == '0);
  // Tick taken at value ...001 is the expiry tick.
  assign w_expire = w_tick && (r_count == CNT_ONE);

  // ---------------------------------------------------------------------------
  // Controller: load > start > en
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
`ifdef BCD_AUTORELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count <= w_load_clamped;
        r_state <= IDLE;
`ifdef BCD_AUTORELOAD_EN
        r_reload <= w_load_clamped;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            // Starting from zero would expire instantly; refuse it.
            if (start && !w_zero) r_state <= RUN;
          end
          RUN: begin
            // Borrow escaping the top digit would mean 0 -> 99..9; never commit it.
            if (w_tick && !w_borrow[DIGITS]) begin
              if (w_expire) begin
                r_done <= 1'b1;
`ifdef BCD_AUTORELOAD_EN
                if (r_reload != '0) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_state <= EXPIRED;
                end
`else
                r_count <= '0;
                r_state <= EXPIRED;
`endif
              end else begin
                r_count <= w_dec_val;
              end
            end
          end
          EXPIRED: begin
            r_count <= '0;
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign count   = r_count;
  assign running = (r_state == RUN);
  assign zero    = w_zero;
  assign done    = r_done;

endmodule
